// File: rtl/corr_pkg.sv
// Shared definitions for the correlator chain: default widths and the
// peak-detector state encoding.
package corr_pkg;

    localparam int CORR_W_DEF = 25;
    localparam int IDX_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/corr_mag.sv
// Combinational magnitude and sign of a two's-complement correlation sum.
// The most-negative input maps to 2^(CORR_W-1) without saturating.
module corr_mag #(
    parameter int CORR_W = 25
) (
    input  logic [CORR_W-1:0] i_corr,
    output logic [CORR_W-1:0] o_mag,
    output logic              o_neg
);

    assign o_neg = i_corr[CORR_W-1];
    assign o_mag = o_neg ? (~i_corr + CORR_W'(1)) : i_corr;

endmodule

// File: rtl/corr_peak_detector.sv
// Tracks runs of above-threshold correlation magnitudes, reports the largest
// (earliest on ties) through a one-deep valid/ready register, then holds off.
module corr_peak_detector
    import corr_pkg::*;
#(
    parameter int CORR_W    = CORR_W_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int MAX_TRACK = 20,
    parameter int HOLDOFF   = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     sample_valid,
    input  logic signed [CORR_W-1:0] corr_in,
    input  logic [CORR_W-1:0]        thr,
    output logic                     peak_valid,
    input  logic                     peak_ready,
    output logic [CORR_W-1:0]        peak_mag,
    output logic                     peak_neg,
    output logic [IDX_W-1:0]         peak_idx,
    output logic [7:0]               drop_cnt,
    output logic                     busy
);

    localparam int RUN_W  = $clog2(MAX_TRACK + 1);
    localparam int HCNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    state_t              r_state, w_state_next;
    logic [IDX_W-1:0]    r_idx;
    logic [RUN_W-1:0]    r_run, w_run_next, w_run_inc;
    logic [HCNT_W-1:0]   r_hcnt, w_hcnt_next;
    logic [CORR_W-1:0]   r_best_mag, w_best_mag_next;
    logic                r_best_neg, w_best_neg_next;
    logic [IDX_W-1:0]    r_best_idx, w_best_idx_next;

    logic                r_pvalid;
    logic [CORR_W-1:0]   r_pmag;
    logic                r_pneg;
    logic [IDX_W-1:0]    r_pidx;
    logic [7:0]          r_drop;

    logic [CORR_W-1:0]   w_mag;
    logic                w_neg;
    logic                w_sample, w_above, w_report;

    corr_mag #(.CORR_W(CORR_W)) u_mag (
        .i_corr (corr_in),
        .o_mag  (w_mag),
        .o_neg  (w_neg)
    );

    assign w_sample  = en & sample_valid;
    assign w_above   = (w_mag >= thr);
    assign w_run_inc = r_run + RUN_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_run_next      = r_run;
        w_hcnt_next     = r_hcnt;
        w_best_mag_next = r_best_mag;
        w_best_neg_next = r_best_neg;
        w_best_idx_next = r_best_idx;
        w_report        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sample && w_above) begin
                    w_best_mag_next = w_mag;
                    w_best_neg_next = w_neg;
                    w_best_idx_next = r_idx;
                    w_run_next      = RUN_W'(1);
                    w_state_next    = TRACK;
                    if (MAX_TRACK == 1) begin
                        w_report = 1'b1;
                    end
                end
            end
            TRACK: begin
                if (w_sample) begin
                    if (w_above) begin
                        // strict compare keeps the earliest sample on ties
                        if (w_mag > r_best_mag) begin
                            w_best_mag_next = w_mag;
                            w_best_neg_next = w_neg;
                            w_best_idx_next = r_idx;
                        end
                        w_run_next = w_run_inc;
                        if (w_run_inc == RUN_W'(MAX_TRACK)) begin
                            w_report = 1'b1;
                        end
                    end else begin
                        w_report = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (w_sample) begin
                    w_hcnt_next = r_hcnt - HCNT_W'(1);
                    if (r_hcnt == HCNT_W'(1)) begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (w_report) begin
            w_state_next = (HOLDOFF == 0) ? IDLE : HOLD;
            w_hcnt_next  = HCNT_W'(HOLDOFF);
            w_run_next   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_run      <= '0;
            r_hcnt     <= '0;
            r_best_mag <= '0;
            r_best_neg <= 1'b0;
            r_best_idx <= '0;
        end else begin
            if (w_sample) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            r_run      <= w_run_next;
            r_hcnt     <= w_hcnt_next;
            r_best_mag <= w_best_mag_next;
            r_best_neg <= w_best_neg_next;
            r_best_idx <= w_best_idx_next;
        end
    end

    // A simultaneous accept frees the slot, so a new report never drops then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pvalid <= 1'b0;
            r_pmag   <= '0;
            r_pneg   <= 1'b0;
            r_pidx   <= '0;
            r_drop   <= '0;
        end else if (w_report) begin
            if (!r_pvalid || peak_ready) begin
                r_pvalid <= 1'b1;
                r_pmag   <= w_best_mag_next;
                r_pneg   <= w_best_neg_next;
                r_pidx   <= w_best_idx_next;
            end else if (r_drop != 8'hFF) begin
                r_drop <= r_drop + 8'd1;
            end
        end else if (r_pvalid && peak_ready) begin
            r_pvalid <= 1'b0;
        end
    end

    assign peak_valid = r_pvalid;
    assign peak_mag   = r_pmag;
    assign peak_neg   = r_pneg;
    assign peak_idx   = r_pidx;
    assign drop_cnt   = r_drop;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_corr_peak_detector.sv
// Directed bench for corr_peak_detector: a vector table for the single-peak,
// holdoff and most-negative cases, plus sequences for multi-cycle corners.
module tb_corr_peak_detector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        sample_valid = 1'b0;
    logic [24:0] corr_in = '0;
    logic [24:0] thr = '0;
    logic        peak_valid;
    logic        peak_ready = 1'b1;
    logic [24:0] peak_mag;
    logic        peak_neg;
    logic [15:0] peak_idx;
    logic [7:0]  drop_cnt;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [24:0] corr;
        logic [24:0] thr;
        logic        exp_valid;
        logic        exp_busy;
        logic [24:0] exp_mag;
        logic        exp_neg;
        logic [15:0] exp_idx;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    corr_peak_detector #(
        .CORR_W(25), .IDX_W(16), .MAX_TRACK(20), .HOLDOFF(20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample_valid (sample_valid),
        .corr_in      (corr_in),
        .thr          (thr),
        .peak_valid   (peak_valid),
        .peak_ready   (peak_ready),
        .peak_mag     (peak_mag),
        .peak_neg     (peak_neg),
        .peak_idx     (peak_idx),
        .drop_cnt     (drop_cnt),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int c, input int t, input bit v, input bit b,
                       input int m, input bit n, input int i);
        vec_t e;
        e.corr      = 25'(c);
        e.thr       = 25'(t);
        e.exp_valid = v;
        e.exp_busy  = b;
        e.exp_mag   = 25'(m);
        e.exp_neg   = n;
        e.exp_idx   = 16'(i);
        vecs.push_back(e);
    endtask

    task automatic do_sample(input int c, input int t);
        @(negedge clk);
        en           = 1'b1;
        sample_valid = 1'b1;
        corr_in      = 25'(c);
        thr          = 25'(t);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    // n consecutive samples that never cross threshold
    task automatic bulk(input int n);
        @(negedge clk);
        en           = 1'b1;
        sample_valid = 1'b1;
        corr_in      = '0;
        thr          = 25'h1FF_FFFF;
        repeat (n) @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic check_report(input string name, input int m, input bit n, input int i);
        check({name, "_valid"}, 32'(peak_valid), 32'(1'b1));
        check({name, "_mag"},   32'(peak_mag),   32'(m));
        check({name, "_neg"},   32'(peak_neg),   32'(n));
        check({name, "_idx"},   32'(peak_idx),   32'(i));
        $display("report %s: mag=%0d neg=%0d idx=%0d drop=%0d", name, peak_mag, peak_neg, peak_idx, drop_cnt);
    endtask

    initial begin
        // single peak, idx 0..4
        add(50,   100, 0, 0, 0, 0, 0);
        add(120,  100, 0, 1, 0, 0, 0);
        add(-300, 100, 0, 1, 0, 0, 0);
        add(200,  100, 0, 1, 0, 0, 0);
        add(40,   100, 1, 1, 300, 1, 2);
        // above-threshold burst inside holdoff, idx 5..24
        for (int i = 5; i < 24; i++) add(1000, 100, 0, 1, 0, 0, 0);
        add(1000, 100, 0, 0, 0, 0, 0);
        // first sample after holdoff, most-negative input
        add(-16777216, 100, 0, 1, 0, 0, 0);
        add(7,         100, 1, 1, 16777216, 1, 25);
        for (int i = 27; i < 46; i++) add(0, 100, 0, 1, 0, 0, 0);
        add(0, 100, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(peak_valid), 32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_mag",   32'(peak_mag),   32'd0);
        check("rst_idx",   32'(peak_idx),   32'd0);
        check("rst_drop",  32'(drop_cnt),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            do_sample(int'($signed(vecs[i].corr)), int'(vecs[i].thr));
            $display("vec %0d: corr=%0d valid=%0d busy=%0d", i, $signed(vecs[i].corr), peak_valid, busy);
            check($sformatf("tbl%0d_valid", i), 32'(peak_valid), 32'(vecs[i].exp_valid));
            check($sformatf("tbl%0d_busy", i),  32'(busy),       32'(vecs[i].exp_busy));
            if (vecs[i].exp_valid) begin
                check($sformatf("tbl%0d_mag", i), 32'(peak_mag), 32'(vecs[i].exp_mag));
                check($sformatf("tbl%0d_neg", i), 32'(peak_neg), 32'(vecs[i].exp_neg));
                check($sformatf("tbl%0d_idx", i), 32'(peak_idx), 32'(vecs[i].exp_idx));
            end
        end

        // forced report at 20 samples, hold 20, second report at sample 60 (idx 47..106)
        for (int k = 1; k <= 60; k++) begin
            do_sample(5, 0);
            check($sformatf("force%0d_valid", k), 32'(peak_valid), 32'((k == 20) || (k == 60)));
            check($sformatf("force%0d_busy", k),  32'(busy),       32'(k != 40));
            if (k == 20) check_report("force1", 5, 0, 47);
            if (k == 60) check_report("force2", 5, 0, 87);
        end
        bulk(20);
        check("flush1_busy", 32'(busy), 32'd0);
        check("flush1_valid", 32'(peak_valid), 32'd0);

        // backpressure: A at idx 127, B dropped, C loaded with same-cycle accept
        peak_ready = 1'b0;
        do_sample(200, 100);
        do_sample(0, 100);
        check_report("bpA", 200, 0, 127);
        bulk(20);
        do_sample(-150, 100);
        do_sample(0, 100);
        check_report("bpB_retained", 200, 0, 127);
        check("bpB_drop", 32'(drop_cnt), 32'd1);
        bulk(20);
        check_report("bp_stable", 200, 0, 127);
        do_sample(333, 100);
        peak_ready = 1'b1;
        do_sample(0, 100);
        check_report("bpC", 333, 0, 171);
        check("bpC_drop", 32'(drop_cnt), 32'd1);
        bulk(20);
        check("flush2_valid", 32'(peak_valid), 32'd0);
        check("flush2_busy",  32'(busy),       32'd0);

        // en low freezes FSM and idx (peak at idx 193, then 194)
        do_sample(500, 100);
        @(negedge clk);
        en           = 1'b0;
        sample_valid = 1'b1;
        corr_in      = '0;
        thr          = 25'd100;
        repeat (5) @(posedge clk);
        #1;
        check("en_busy",  32'(busy),       32'd1);
        check("en_valid", 32'(peak_valid), 32'd0);
        sample_valid = 1'b0;
        en           = 1'b1;
        do_sample(600, 100);
        do_sample(0, 100);
        check_report("en", 600, 0, 194);
        bulk(20);

        // reset mid-TRACK discards the peak and restarts idx
        do_sample(500, 100);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst2_busy",  32'(busy),       32'd0);
        check("rst2_valid", 32'(peak_valid), 32'd0);
        check("rst2_mag",   32'(peak_mag),   32'd0);
        check("rst2_idx",   32'(peak_idx),   32'd0);
        check("rst2_drop",  32'(drop_cnt),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_sample(0, 100);
        check("post_rst_valid", 32'(peak_valid), 32'd0);
        check("post_rst_busy",  32'(busy),       32'd0);
        do_sample(500, 100);
        do_sample(0, 100);
        check_report("post_rst", 500, 0, 1);
        bulk(20);

        // idx wrap: fill idx 23..0xFFFE, peak spans 0xFFFF -> 0
        bulk(65535 - 23);
        do_sample(800, 100);
        do_sample(-900, 100);
        do_sample(0, 100);
        check_report("wrap", 900, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
